kfx86_flags_writeback: RTL and testbench

Registered stage directly downstream of the KFX86 ALU. It accepts the ALU result and flag vector through a valid/ready handshake, commits the architectural FLAGS register with per-opcode update rules, and presents the result to the register-file write port. It also executes the flag-control micro-commands (CLC/STC/CMC/CLI/STI/CLD/STD, SAHF, POPF) and feeds the committed flags back to the ALU `source_flags` input.

---
 rtl/kfx86_flags_writeback.sv | 181 ++++++++++++++++++
 tb/tb_kfx86_flags_writeback.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/kfx86_flags_writeback.sv
// rtl/kfx86_flags_writeback.sv - KFX86 ALU flags commit and register write-back stage (optional KFX86_FLAGS_RESERVED_EN)
package kfx86_flags_pkg;
  typedef struct packed {
    logic o;
    logic d;
    logic i;
    logic t;
    logic s;
    logic z;
    logic a;
    logic p;
    logic c;
  } flags_t;
endpackage

module kfx86_flags_writeback
  import kfx86_flags_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  flags_t      alu_flags,
  input  logic        alu_word,
  input  logic [2:0]  alu_dest,
  output flags_t      source_flags,
  input  logic [3:0]  flag_cmd,
  input  logic [15:0] flag_load,
  output logic [15:0] flags_word,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_dest,
  output logic        wb_word,
  output logic        wb_write
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_SBB = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_CMP = 5'b00111;

  localparam logic [3:0] CMD_CLC  = 4'd1;
  localparam logic [3:0] CMD_STC  = 4'd2;
  localparam logic [3:0] CMD_CMC  = 4'd3;
  localparam logic [3:0] CMD_CLI  = 4'd4;
  localparam logic [3:0] CMD_STI  = 4'd5;
  localparam logic [3:0] CMD_CLD  = 4'd6;
  localparam logic [3:0] CMD_STD  = 4'd7;
  localparam logic [3:0] CMD_SAHF = 4'd8;
  localparam logic [3:0] CMD_POPF = 4'd9;

`ifdef KFX86_FLAGS_RESERVED_EN
  localparam logic [15:0] RESERVED_ONES = 16'hF002;
`else
  localparam logic [15:0] RESERVED_ONES = 16'h0000;
`endif

  flags_t      r_flags;
  logic        r_wb_valid;
  logic [15:0] r_wb_data;
  logic [2:0]  r_wb_dest;
  logic        r_wb_word;
  logic        r_wb_write;

  logic        w_accept;
  flags_t      w_flags_alu;
  flags_t      w_flags_next;
  logic        w_unused_load;

  // Reserved, I/O-privilege and unused SAHF/POPF bits carry no state here.
  assign w_unused_load = &{flag_load[15:12], flag_load[5], flag_load[3], flag_load[1]};

  assign alu_ready = ~r_wb_valid | wb_ready;
  assign w_accept  = alu_valid & alu_ready;

  // Flags after the ALU result is folded in (unchanged when nothing is accepted).
  always_comb begin
    w_flags_alu = r_flags;
    if (w_accept) begin
      case (alu_opcode)
        OP_ADD, OP_ADC, OP_SBB, OP_SUB, OP_CMP: begin
          w_flags_alu.c = alu_flags.c;
          w_flags_alu.p = alu_flags.p;
          w_flags_alu.a = alu_flags.a;
          w_flags_alu.z = alu_flags.z;
          w_flags_alu.s = alu_flags.s;
          w_flags_alu.o = alu_flags.o;
        end
        OP_OR, OP_AND, OP_XOR: begin
          w_flags_alu.c = alu_flags.c;
          w_flags_alu.p = alu_flags.p;
          w_flags_alu.a = 1'b0;
          w_flags_alu.z = alu_flags.z;
          w_flags_alu.s = alu_flags.s;
          w_flags_alu.o = alu_flags.o;
        end
        default: ;
      endcase
    end
  end

  // Flag micro-command layered on top of the post-ALU flags.
  always_comb begin
    w_flags_next = w_flags_alu;
    case (flag_cmd)
      CMD_CLC:  w_flags_next.c = 1'b0;
      CMD_STC:  w_flags_next.c = 1'b1;
      CMD_CMC:  w_flags_next.c = ~w_flags_alu.c;
      CMD_CLI:  w_flags_next.i = 1'b0;
      CMD_STI:  w_flags_next.i = 1'b1;
      CMD_CLD:  w_flags_next.d = 1'b0;
      CMD_STD:  w_flags_next.d = 1'b1;
      CMD_SAHF: begin
        w_flags_next.s = flag_load[7];
        w_flags_next.z = flag_load[6];
        w_flags_next.a = flag_load[4];
        w_flags_next.p = flag_load[2];
        w_flags_next.c = flag_load[0];
      end
      CMD_POPF: begin
        w_flags_next.o = flag_load[11];
        w_flags_next.d = flag_load[10];
        w_flags_next.i = flag_load[9];
        w_flags_next.t = flag_load[8];
        w_flags_next.s = flag_load[7];
        w_flags_next.z = flag_load[6];
        w_flags_next.a = flag_load[4];
        w_flags_next.p = flag_load[2];
        w_flags_next.c = flag_load[0];
      end
      default: ;
    endcase
  end

  // Architectural FLAGS register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
    end else begin
      r_flags <= w_flags_next;
    end
  end

  // Write-back output register: load on accept, drop valid once consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= 16'h0000;
      r_wb_dest  <= 3'd0;
      r_wb_word  <= 1'b0;
      r_wb_write <= 1'b0;
    end else if (w_accept) begin
      r_wb_valid <= 1'b1;
      r_wb_data  <= alu_word ? alu_out : {8'h00, alu_out[7:0]};
      r_wb_dest  <= alu_dest;
      r_wb_word  <= alu_word;
      r_wb_write <= (alu_opcode != OP_CMP);
    end else if (r_wb_valid && wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign source_flags = r_flags;
  assign flags_word   = {4'b0000, r_flags.o, r_flags.d, r_flags.i, r_flags.t,
                         r_flags.s, r_flags.z, 1'b0, r_flags.a,
                         1'b0, r_flags.p, 1'b0, r_flags.c} | RESERVED_ONES;

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;
  assign wb_dest  = r_wb_dest;
  assign wb_word  = r_wb_word;
  assign wb_write = r_wb_write;

endmodule

// File: tb/tb_kfx86_flags_writeback.sv
// tb/tb_kfx86_flags_writeback.sv - self-checking bench for kfx86_flags_writeback
module tb_kfx86_flags_writeback;
  import kfx86_flags_pkg::*;

`ifdef KFX86_FLAGS_RESERVED_EN
  localparam logic [15:0] RES = 16'hF002;
`else
  localparam logic [15:0] RES = 16'h0000;
`endif
  localparam logic [15:0] ARITH_MASK = 16'h08D5;
  localparam logic [15:0] LOGIC_MASK = 16'h08C5;
  localparam logic [15:0] SAHF_MASK  = 16'h00D5;
  localparam logic [15:0] POPF_MASK  = 16'h0FD5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_out;
  flags_t      alu_flags;
  logic        alu_word;
  logic [2:0]  alu_dest;
  flags_t      source_flags;
  logic [3:0]  flag_cmd;
  logic [15:0] flag_load;
  logic [15:0] flags_word;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic        wb_word;
  logic        wb_write;

  kfx86_flags_writeback dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_word(alu_word), .alu_dest(alu_dest),
    .source_flags(source_flags), .flag_cmd(flag_cmd), .flag_load(flag_load),
    .flags_word(flags_word), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_word(wb_word), .wb_write(wb_write)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: flags kept as an 8088-layout word, write-back as plain fields.
  logic [15:0] m_flags;
  logic        m_wb_valid;
  logic [15:0] m_wb_data;
  logic [2:0]  m_wb_dest;
  logic        m_wb_word;
  logic        m_wb_write;

  function automatic logic [15:0] to_word(input flags_t f);
    logic [15:0] w;
    w = 16'h0000;
    w[0] = f.c; w[2] = f.p; w[4] = f.a; w[6] = f.z; w[7] = f.s;
    w[8] = f.t; w[9] = f.i; w[10] = f.d; w[11] = f.o;
    return w;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 16'h0000; m_wb_valid = 1'b0; m_wb_data = 16'h0000;
    m_wb_dest = 3'd0; m_wb_word = 1'b0; m_wb_write = 1'b0;
  endtask

  task automatic model_step(input logic acc);
    logic [15:0] aw;
    aw = to_word(alu_flags);
    if (acc) begin
      if (alu_opcode inside {5'd0, 5'd2, 5'd3, 5'd5, 5'd7})
        m_flags = (m_flags & ~ARITH_MASK) | (aw & ARITH_MASK);
      else if (alu_opcode inside {5'd1, 5'd4, 5'd6})
        m_flags = (m_flags & ~ARITH_MASK) | (aw & LOGIC_MASK);
      m_wb_valid = 1'b1;
      m_wb_data  = alu_word ? alu_out : (alu_out & 16'h00FF);
      m_wb_dest  = alu_dest;
      m_wb_word  = alu_word;
      m_wb_write = (alu_opcode != 5'd7);
    end else if (m_wb_valid && wb_ready) begin
      m_wb_valid = 1'b0;
    end
    case (flag_cmd)
      4'd1: m_flags[0]  = 1'b0;
      4'd2: m_flags[0]  = 1'b1;
      4'd3: m_flags[0]  = ~m_flags[0];
      4'd4: m_flags[9]  = 1'b0;
      4'd5: m_flags[9]  = 1'b1;
      4'd6: m_flags[10] = 1'b0;
      4'd7: m_flags[10] = 1'b1;
      4'd8: m_flags = (m_flags & ~SAHF_MASK) | (flag_load & SAHF_MASK);
      4'd9: m_flags = flag_load & POPF_MASK;
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wb_valid"}, {15'd0, wb_valid}, {15'd0, m_wb_valid});
    check({tag, ".wb_data"}, wb_data, m_wb_data);
    check({tag, ".wb_dest"}, {13'd0, wb_dest}, {13'd0, m_wb_dest});
    check({tag, ".wb_word"}, {15'd0, wb_word}, {15'd0, m_wb_word});
    check({tag, ".wb_write"}, {15'd0, wb_write}, {15'd0, m_wb_write});
    check({tag, ".flags_word"}, flags_word, m_flags | RES);
    check({tag, ".source_flags"}, to_word(source_flags), m_flags);
  endtask

  // One clock: inputs already driven; check ready, predict, clock, compare.
  task automatic do_cycle(input string tag);
    logic acc;
    #1;
    check({tag, ".alu_ready"}, {15'd0, alu_ready}, {15'd0, ~m_wb_valid | wb_ready});
    acc = alu_valid & (~m_wb_valid | wb_ready);
    model_step(acc);
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; flag_cmd = 4'd0; flag_load = 16'h0000;
  endtask

  task automatic set_alu(input logic [4:0] op, input logic [15:0] res, input logic word,
                         input logic [2:0] dest, input logic [8:0] fl);
    alu_valid = 1'b1; alu_opcode = op; alu_out = res; alu_word = word; alu_dest = dest;
    alu_flags = fl;
  endtask

  initial begin
    logic [8:0] rf;
    reset_n = 1'b0; wb_ready = 1'b1; alu_opcode = 5'd0; alu_out = 16'h0000;
    alu_flags = '0; alu_word = 1'b0; alu_dest = 3'd0;
    idle_inputs();
    model_reset();
    #1;
    check("reset.flags_word", flags_word, RES);
    check("reset.alu_ready", {15'd0, alu_ready}, 16'd1);
    check("reset.wb_valid", {15'd0, wb_valid}, 16'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Reset mid-stall: load a result, stall it, then assert reset between edges.
    set_alu(5'd0, 16'h1234, 1'b1, 3'd5, 9'h1FF);
    flag_cmd = 4'd5;
    do_cycle("prestall");
    idle_inputs(); wb_ready = 1'b0;
    do_cycle("stall_hold");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midreset.wb_valid", {15'd0, wb_valid}, 16'd0);
    check("midreset.flags_word", flags_word, RES);
    check("midreset.alu_ready", {15'd0, alu_ready}, 16'd1);
    @(posedge clock); #1;
    check_outputs("midreset");
    reset_n = 1'b1; wb_ready = 1'b1;

    // ADD byte FF+01 with C,A,Z,P set.
    set_alu(5'd0, 16'hAB00, 1'b0, 3'd1, 9'b0_0000_0_1_1_1_1 & 9'b0_0000_0_1_1_1_1);
    alu_flags = '0;
    alu_flags.c = 1'b1; alu_flags.a = 1'b1; alu_flags.z = 1'b1; alu_flags.p = 1'b1;
    do_cycle("add_byte");
    check("add_byte.flags_const", flags_word, 16'h0055 | RES);
    check("add_byte.data_const", wb_data, 16'h0000);
    idle_inputs();
    do_cycle("drain1");

    // CMP held for three stall cycles; a competing offer must not be taken.
    wb_ready = 1'b0;
    set_alu(5'd7, 16'h5A5A, 1'b1, 3'd3, 9'h081);
    do_cycle("cmp_acc");
    check("cmp.wb_write_const", {15'd0, wb_write}, 16'd0);
    set_alu(5'd0, 16'hFFFF, 1'b1, 3'd7, 9'h1FF);
    for (int i = 0; i < 3; i++) do_cycle("cmp_stall");
    idle_inputs(); wb_ready = 1'b1;
    do_cycle("cmp_release");

    // XOR with A=1 already committed: A must clear.
    flag_cmd = 4'd8; flag_load = 16'h0010;
    do_cycle("sahf_a");
    idle_inputs();
    rf = '0; rf[6] = 1'b1; rf[4] = 1'b1; rf[0] = 1'b1;
    set_alu(5'd6, 16'h0000, 1'b1, 3'd2, 9'h000);
    alu_flags = '0; alu_flags.z = 1'b1; alu_flags.p = 1'b1; alu_flags.a = 1'b1;
    do_cycle("xor");
    check("xor.a_clear", {15'd0, flags_word[4]}, 16'd0);

    // ADD with C=0 plus CMC, then plus POPF.
    set_alu(5'd0, 16'h0042, 1'b1, 3'd4, 9'h000);
    flag_cmd = 4'd3;
    do_cycle("add_cmc");
    check("add_cmc.c", {15'd0, flags_word[0]}, 16'd1);
    flag_cmd = 4'd9; flag_load = 16'h0F01;
    do_cycle("add_popf");
    check("add_popf.const", flags_word, 16'h0F01 | RES);
    idle_inputs();

    // Four back-to-back accepts.
    for (int i = 0; i < 4; i++) begin
      set_alu(5'(i), 16'h1000 * 16'(i + 1) + 16'h00A5, 1'b1, 3'(i), 9'(i * 37));
      do_cycle("b2b");
    end
    idle_inputs();
    do_cycle("b2b_drain");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      alu_valid  = ($urandom_range(0, 3) != 0);
      wb_ready   = ($urandom_range(0, 3) != 0);
      alu_opcode = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      alu_out    = 16'($urandom);
      alu_flags  = 9'($urandom);
      alu_word   = 1'($urandom);
      alu_dest   = 3'($urandom);
      flag_cmd   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      flag_load  = 16'($urandom);
      do_cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
